// File: rtl/serial_mod_check_ctrl.sv
// Bit-serial divisibility controller: takes W-bit words, shifts them MSB-first
// through a mod-DIVISOR residue tracker and returns divisible flag + remainder.
module serial_mod_check_ctrl #(
  parameter int W       = 8,
  parameter int DIVISOR = 5,
  parameter int REM_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_cont,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_div,
  output logic [REM_W-1:0] res_rem,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             busy
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [REM_W:0] DIV_T = (REM_W+1)'(DIVISOR);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [REM_W-1:0]   residue_q, residue_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REM_W:0]     step_t, step_sub;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      residue_q <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      residue_q <= residue_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)      state_d = SHIFT;
      SHIFT:   if (cnt_q == '0)   state_d = DONE;
      DONE:    if (res_ready)     state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // t = 2*r + b never exceeds 2*DIVISOR-1, so a single conditional subtract reduces it
  assign step_t   = {residue_q, shreg_q[W-1]};
  assign step_sub = (step_t >= DIV_T) ? (step_t - DIV_T) : step_t;

  always_comb begin
    residue_d = residue_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = CNT_W'(W-1);
          if (!in_cont) residue_d = '0;
        end
      end
      SHIFT: begin
        residue_d = step_sub[REM_W-1:0];
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q - 1'b1;
      end
      default: ;
    endcase
    if (clear) residue_d = '0;
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    ser_valid = (state_q == SHIFT);
    ser_bit   = (state_q == SHIFT) && shreg_q[W-1];
    res_valid = (state_q == DONE);
    res_div   = (state_q == DONE) && (residue_q == '0);
    res_rem   = (state_q == DONE) ? residue_q : '0;
  end

endmodule

// File: tb/tb_serial_mod_check_ctrl.sv
// Bench for serial_mod_check_ctrl: word-level modular reference model plus a
// lock-step bit-serial mod-5 FSM fed from ser_bit.
module tb_serial_mod_check_ctrl;

  localparam int W = 8;
  localparam int DIVISOR = 5;
  localparam int REM_W = 3;

  logic clk = 1'b0;
  logic rst, clear, in_valid, in_cont, res_ready;
  logic [W-1:0] in_data;
  logic in_ready, res_valid, res_div, ser_valid, ser_bit, busy;
  logic [REM_W-1:0] res_rem;

  int n_checks = 0;
  int n_fail = 0;
  int model_rem = 0;
  int fsm_s;

  serial_mod_check_ctrl #(.W(W), .DIVISOR(DIVISOR), .REM_W(REM_W)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_cont(in_cont),
    .res_valid(res_valid), .res_ready(res_ready), .res_div(res_div), .res_rem(res_rem),
    .ser_valid(ser_valid), .ser_bit(ser_bit), .busy(busy)
  );

  always #5 clk = ~clk;

  // Standalone mod-5 recogniser, written as an explicit transition table
  always @(posedge clk or posedge rst) begin
    if (rst) fsm_s <= 0;
    else if (ser_valid) begin
      case (fsm_s)
        0: fsm_s <= ser_bit ? 1 : 0;
        1: fsm_s <= ser_bit ? 3 : 2;
        2: fsm_s <= ser_bit ? 0 : 4;
        3: fsm_s <= ser_bit ? 2 : 1;
        default: fsm_s <= ser_bit ? 4 : 3;
      endcase
    end
  end

  function automatic int model_next(input int rem, input int d, input bit c);
    return ((c ? rem : 0) * (2 ** W) + d) % DIVISOR;
  endfunction

  // Offers one word, collects its serial bits and result; res_ready held at 1
  task automatic send_word(input logic [W-1:0] d, input logic c,
                           output logic [REM_W-1:0] rem, output logic dv,
                           output int lat, output logic [W-1:0] bits, output bit timeout);
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_cont = c; res_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_data = W'($urandom); in_cont = 1'($urandom);
    lat = 0; bits = '0; timeout = 1'b1; rem = '0; dv = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ser_valid) bits = {bits[W-2:0], ser_bit};
      if (res_valid) begin
        rem = res_rem; dv = res_div; timeout = 1'b0;
        break;
      end
      @(posedge clk);
      lat++;
    end
    @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_cont = 1'b0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, res_valid, res_div, res_rem, ser_valid, ser_bit, busy} !== {1'b1, 7'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b rv=%b div=%b rem=%0d sv=%b sb=%b busy=%b, need ready=1 rest 0",
               in_ready, res_valid, res_div, res_rem, ser_valid, ser_bit, busy);
    end
    rst = 1'b0;
    model_rem = 0;
    $display("reset: in_ready=%b busy=%b", in_ready, busy);
  endtask

  task automatic test_basic;
    logic [REM_W-1:0] rem; logic dv; int lat; logic [W-1:0] bits; bit to;
    int vals[3] = '{25, 27, 255};
    foreach (vals[k]) begin
      send_word(W'(vals[k]), 1'b0, rem, dv, lat, bits, to);
      model_rem = model_next(model_rem, vals[k], 1'b0);
      n_checks++;
      if (to || rem !== REM_W'(model_rem) || dv !== (model_rem == 0)) begin
        n_fail++;
        $display("FAIL basic_result data=%0d: got rem=%0d div=%b to=%b, need rem=%0d div=%b",
                 vals[k], rem, dv, to, model_rem, model_rem == 0);
      end
      n_checks++;
      if (lat !== W || bits !== W'(vals[k])) begin
        n_fail++;
        $display("FAIL basic_serial data=%0d: got lat=%0d bits=%b, need lat=%0d bits=%b",
                 vals[k], lat, bits, W, W'(vals[k]));
      end
      $display("basic: data=%0d rem=%0d div=%b lat=%0d bits=%b", vals[k], rem, dv, lat, bits);
    end
  endtask

  task automatic test_aggregate;
    logic [REM_W-1:0] rem; logic dv; int lat; logic [W-1:0] bits; bit to;
    int   ds[3] = '{1, 4, 4};
    bit   cs[3] = '{1'b0, 1'b1, 1'b0};
    int   exp_rem[3] = '{1, 0, 4};
    for (int k = 0; k < 3; k++) begin
      send_word(W'(ds[k]), cs[k], rem, dv, lat, bits, to);
      model_rem = model_next(model_rem, ds[k], cs[k]);
      n_checks++;
      if (to || rem !== REM_W'(exp_rem[k]) || rem !== REM_W'(model_rem) || dv !== (exp_rem[k] == 0)) begin
        n_fail++;
        $display("FAIL aggregate word %0d: got rem=%0d div=%b, need rem=%0d div=%b",
                 k, rem, dv, exp_rem[k], exp_rem[k] == 0);
      end
      $display("aggregate: data=%0d cont=%b rem=%0d div=%b", ds[k], cs[k], rem, dv);
    end
  endtask

  task automatic test_backpressure;
    logic [REM_W-1:0] rem, rem0; logic dv, dv0; int lat; logic [W-1:0] bits; bit to;
    bit seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd27; in_cont = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    model_rem = model_next(model_rem, 27, 1'b0);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL bp_wait_result: got no res_valid, need res_valid"); end
    rem0 = res_rem; dv0 = res_div;
    n_checks++;
    if (rem0 !== REM_W'(model_rem) || dv0 !== (model_rem == 0)) begin
      n_fail++;
      $display("FAIL bp_result: got rem=%0d div=%b, need rem=%0d div=%b", rem0, dv0, model_rem, model_rem == 0);
    end
    in_valid = 1'b1; in_data = 8'd10; in_cont = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b1 || res_rem !== rem0 || res_div !== dv0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cycle %0d: got rv=%b rem=%0d div=%b ready=%b, need rv=1 rem=%0d div=%b ready=0",
                 i, res_valid, res_rem, res_div, in_ready, rem0, dv0);
      end
    end
    in_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got rv=%b ready=%b busy=%b, need rv=0 ready=1 busy=0", res_valid, in_ready, busy);
    end
    // residue of 27 kept; the ignored word 10 must not have disturbed it
    send_word(8'd3, 1'b1, rem, dv, lat, bits, to);
    model_rem = model_next(model_rem, 3, 1'b1);
    n_checks++;
    if (to || rem !== REM_W'(model_rem) || dv !== (model_rem == 0)) begin
      n_fail++;
      $display("FAIL bp_follow: got rem=%0d div=%b, need rem=%0d div=%b", rem, dv, model_rem, model_rem == 0);
    end
    $display("backpressure: held rem=%0d div=%b, follow-on rem=%0d", rem0, dv0, rem);
  endtask

  task automatic test_clear;
    logic [REM_W-1:0] rem; logic dv; int lat; logic [W-1:0] bits; bit to;
    bit pulsed = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd25; in_cont = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); pulsed |= res_valid;
      @(posedge clk);
    end
    @(negedge clk); clear = 1'b1;
    @(posedge clk);
    @(negedge clk); clear = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || ser_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle: got ready=%b busy=%b sv=%b, need ready=1 busy=0 sv=0", in_ready, busy, ser_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); pulsed |= res_valid;
    end
    n_checks++;
    if (pulsed) begin n_fail++; $display("FAIL clear_no_result: got res_valid pulse, need none"); end
    model_rem = 0;
    // clear coinciding with an offered word blocks acceptance
    in_valid = 1'b1; in_data = 8'd7; clear = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; clear = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_vs_accept: got busy=%b ready=%b, need busy=0 ready=1", busy, in_ready);
    end
    send_word(8'd3, 1'b1, rem, dv, lat, bits, to);
    model_rem = model_next(model_rem, 3, 1'b1);
    n_checks++;
    if (to || rem !== 3'd3 || dv !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_residue_zeroed: got rem=%0d div=%b, need rem=3 div=0", rem, dv);
    end
    $display("clear: after-clear word rem=%0d div=%b", rem, dv);
  endtask

  task automatic test_async_reset;
    logic [REM_W-1:0] rem; logic dv; int lat; logic [W-1:0] bits; bit to;
    bit seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd77; in_cont = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = res_valid;
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (!seen || res_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got seen_done=%b rv=%b ready=%b, need seen_done=1 rv=0 ready=1",
               seen, res_valid, in_ready);
    end
    @(negedge clk); rst = 1'b0;
    model_rem = 0;
    send_word(8'd10, 1'b1, rem, dv, lat, bits, to);
    model_rem = model_next(model_rem, 10, 1'b1);
    n_checks++;
    if (to || rem !== REM_W'(model_rem) || dv !== 1'b1 || fsm_s !== 0) begin
      n_fail++;
      $display("FAIL after_reset_word: got rem=%0d div=%b fsm=s%0d, need rem=0 div=1 fsm=s0", rem, dv, fsm_s);
    end
    $display("async_reset: word 10 rem=%0d div=%b fsm=s%0d", rem, dv, fsm_s);
  endtask

  task automatic test_random;
    logic [REM_W-1:0] rem; logic dv; int lat; logic [W-1:0] bits; bit to;
    int d; bit c;
    for (int k = 0; k < 30; k++) begin
      d = int'($urandom_range(0, 2 ** W - 1));
      c = 1'($urandom);
      send_word(W'(d), c, rem, dv, lat, bits, to);
      model_rem = model_next(model_rem, d, c);
      n_checks++;
      if (to || rem !== REM_W'(model_rem) || dv !== (model_rem == 0) || lat !== W || bits !== W'(d)) begin
        n_fail++;
        $display("FAIL random %0d data=%0d cont=%b: got rem=%0d div=%b lat=%0d bits=%b, need rem=%0d div=%b lat=%0d bits=%b",
                 k, d, c, rem, dv, lat, bits, model_rem, model_rem == 0, W, W'(d));
      end
      $display("random: data=%0d cont=%b rem=%0d div=%b", d, c, rem, dv);
    end
  endtask

  task automatic test_back_to_back;
    int accepts[$];
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'd200; in_cont = 1'b0; res_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_ready && in_valid) accepts.push_back(cyc);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (accepts.size() < 3) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d acceptances, need >= 3", accepts.size());
    end
    for (int k = 1; k < accepts.size(); k++) begin
      n_checks++;
      if (accepts[k] - accepts[k-1] !== W + 2) begin
        n_fail++;
        $display("FAIL b2b_spacing %0d: got %0d cycles, need %0d", k, accepts[k] - accepts[k-1], W + 2);
      end
    end
    repeat (W + 4) @(negedge clk);
    model_rem = 200 % DIVISOR;
    $display("back_to_back: %0d acceptances", accepts.size());
  endtask

  initial begin
    test_reset;
    test_basic;
    test_aggregate;
    test_backpressure;
    test_clear;
    test_async_reset;
    test_random;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_mod_check_ctrl.md
Name: serial_mod_check_ctrl

Overview:
Controller that sequences the bit-serial divisibility datapath. It accepts parallel words over a valid/ready handshake and serialises each word MSB-first into a mod-DIVISOR residue tracker. For every word it returns a divisible flag and the remainder over a second valid/ready handshake. It can either restart the aggregate value for each word or continue the aggregate across consecutive words. It also exports the serial bit stream so a standalone bit-serial divisibility FSM can be run in lock-step for cross-checking.

Parameters:
W, 8, input word width in bits (W >= 1)
DIVISOR, 5, modulus (DIVISOR >= 2)
REM_W, 3, residue width; must satisfy 2^REM_W >= DIVISOR

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
clear  in  1  synchronous abort; highest priority after rst
in_valid  in  1  input word valid
in_ready  out  1  controller can accept a word
in_data  in  W  word to check, serialised MSB first
in_cont  in  1  sampled with in_data: 1 = continue the aggregate from the current residue, 0 = restart from 0
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_div  out  1  aggregate value divisible by DIVISOR (residue == 0)
res_rem  out  REM_W  aggregate value mod DIVISOR
ser_valid  out  1  ser_bit is being applied this cycle
ser_bit  out  1  current serial bit, MSB first
busy  out  1  controller not in IDLE

Behaviour:
Interface: one clock; reset is asynchronous and active-high. Ports are named clk and rst.

Reset (asynchronous, any state):
- state = IDLE; residue = 0; shift register = 0; bit counter = 0.
- All outputs 0 except in_ready, which is 1 because the controller is in IDLE.

States:
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready at edge T0: latch in_data into the shift register; set bit counter = W-1.
  - Residue: if in_cont = 0, residue <= 0; otherwise the residue is kept.
  - Next state: SHIFT.
- SHIFT
  - in_ready = 0; ser_valid = 1; ser_bit = shift register MSB.
  - Each edge: residue <= (2*residue + ser_bit) mod DIVISOR; shift register shifts left; bit counter decrements.
  - After W SHIFT edges (the last one at T0+W) go to DONE.
- DONE
  - res_valid = 1; res_div = (residue == 0); res_rem = residue.
  - Outputs stay stable while res_ready = 0.
  - On res_valid & res_ready: go to IDLE. The residue is retained for a possible in_cont word.

Arithmetic:
- Compute t = 2*residue + bit at REM_W+1 bits.
- If t >= DIVISOR, subtract DIVISOR once. One subtraction is sufficient because t <= 2*DIVISOR-1.
- No `%` operator in RTL.

Timing:
- res_valid rises on edge T0+W, i.e. W cycles after input acceptance.
- Back-to-back throughput is one word per W+2 cycles with res_ready held at 1.

Handshakes:
- No input is accepted outside IDLE. in_valid in SHIFT or DONE is ignored and the word is not consumed.
- Data and in_cont are sampled only at the accepting edge. Later changes have no effect.

clear:
- In any state, the next edge sets state = IDLE and residue = 0. res_valid and ser_valid drop.
- A pending result is discarded.
- A clear coinciding with an in_valid handshake in IDLE wins; the word is not accepted.

Residue visibility:
- The residue is observable only through res_rem in DONE.
- A reset or clear mid-SHIFT never produces a partial result.

Cross-check:
- Feeding ser_bit to a bit-serial mod-5 FSM (reset together, advanced on ser_valid) must leave that FSM in state s0 exactly when res_div = 1.

Test Plan:
1. W=8, DIVISOR=5, in_data=25, in_cont=0, res_ready=1 -> ser_bit sequence 0,0,0,1,1,0,0,1; res_valid at T0+8; res_div=1, res_rem=0.
2. in_data=27, in_cont=0 -> res_div=0, res_rem=2. Repeat with in_data=255 -> res_rem=0, res_div=1.
3. Aggregate:
   - Word 8'h01 with in_cont=0 -> res_rem=1, res_div=0.
   - Then word 8'h04 with in_cont=1 (aggregate 0x0104 = 260) -> res_rem=0, res_div=1.
   - Then word 8'h04 with in_cont=0 -> res_rem=4.
4. Backpressure:
   - Hold res_ready=0 for 5 cycles in DONE -> res_valid, res_div and res_rem stable; in_ready=0.
   - Drive in_valid with 8'd10 during this time -> not accepted.
   - Raise res_ready -> IDLE on the next edge.
5. clear on the 3rd SHIFT cycle of in_data=25 -> IDLE next edge; in_ready=1; res_valid never pulses. The next word, 8'd3 with in_cont=1, returns res_rem=3 (residue was zeroed).
6. Assert rst asynchronously mid-DONE (between edges) -> res_valid=0 immediately and in_ready=1. After release, in_data=10 with in_cont=1 -> res_rem=0, res_div=1, and the lock-step mod-5 FSM reaches s0.
